// File: rtl/rx_pkt_fifo_if.sv
// rtl/rx_pkt_fifo_if.sv - MAC-side and packetin-side streams of the ingress packet buffer
interface rx_pkt_fifo_if;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_sop;
    logic        in_eop;
    logic [2:0]  in_empty;
    logic        in_error;

    logic [63:0] out_data;
    logic        out_valid;
    logic        out_sop;
    logic        out_eop;
    logic [2:0]  out_empty;
    logic        out_ready;

    modport slave (
        input  in_data, in_valid, in_sop, in_eop, in_empty, in_error,
        input  out_ready,
        output out_data, out_valid, out_sop, out_eop, out_empty
    );

    modport master (
        output in_data, in_valid, in_sop, in_eop, in_empty, in_error,
        output out_ready,
        input  out_data, out_valid, out_sop, out_eop, out_empty
    );
endinterface

// File: rtl/rx_pkt_fifo.sv
// rtl/rx_pkt_fifo.sv - store-and-forward ingress packet buffer with commit pointer
module rx_pkt_fifo #(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic         clock,
    input  logic         reset,
    rx_pkt_fifo_if.slave bus,
    output logic [15:0]  pkt_count,
    output logic [15:0]  drop_count
);
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [PW-1:0] DEPTH_P = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [PW-1:0] ONE_P   = {{DEPTH_LOG2{1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DROP} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, cm_ptr_q, cm_ptr_d, rd_ptr_q;
    logic [15:0]     pkt_count_q, drop_count_q;
    logic [16:0]     drop_sum;
    logic [1:0]      drop_add;
    logic            pkt_inc;
    logic            wr_en;
    logic [PW-1:0]   wr_addr;
    logic            full_wr, full_cm;

    // Word layout: {sop, eop, empty[2:0], data[63:0]}
    logic [68:0]     mem [DEPTH];
    logic [68:0]     wr_word, m_word_q, out_word_q;
    logic            m_valid_q, out_valid_q;
    logic            rd_en, out_ld;

    assign full_wr = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
    // A new sop always restarts from the commit point, abandoning any partial packet
    assign full_cm = (cm_ptr_q - rd_ptr_q) == DEPTH_P;
    assign wr_word = {bus.in_sop, bus.in_eop, bus.in_empty, bus.in_data};

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        cm_ptr_d = cm_ptr_q;
        wr_en    = 1'b0;
        wr_addr  = wr_ptr_q;
        pkt_inc  = 1'b0;
        drop_add = 2'd0;
        if (bus.in_valid) begin
            if (bus.in_sop) begin
                if (state_q == S_WRITE) drop_add = 2'd1;
                wr_ptr_d = cm_ptr_q;
                if (full_cm) begin
                    drop_add = drop_add + 2'd1;
                    state_d  = bus.in_eop ? S_IDLE : S_DROP;
                end else begin
                    wr_en   = 1'b1;
                    wr_addr = cm_ptr_q;
                    if (!bus.in_eop) begin
                        wr_ptr_d = cm_ptr_q + ONE_P;
                        state_d  = S_WRITE;
                    end else begin
                        state_d = S_IDLE;
                        if (bus.in_error) begin
                            drop_add = drop_add + 2'd1;
                        end else begin
                            wr_ptr_d = cm_ptr_q + ONE_P;
                            cm_ptr_d = cm_ptr_q + ONE_P;
                            pkt_inc  = 1'b1;
                        end
                    end
                end
            end else if (state_q == S_WRITE) begin
                if (full_wr) begin
                    wr_ptr_d = cm_ptr_q;
                    drop_add = 2'd1;
                    state_d  = bus.in_eop ? S_IDLE : S_DROP;
                end else begin
                    wr_en = 1'b1;
                    if (!bus.in_eop) begin
                        wr_ptr_d = wr_ptr_q + ONE_P;
                    end else begin
                        state_d = S_IDLE;
                        if (bus.in_error) begin
                            wr_ptr_d = cm_ptr_q;
                            drop_add = 2'd1;
                        end else begin
                            wr_ptr_d = wr_ptr_q + ONE_P;
                            cm_ptr_d = wr_ptr_q + ONE_P;
                            pkt_inc  = 1'b1;
                        end
                    end
                end
            end else if (state_q == S_DROP && bus.in_eop) begin
                state_d = S_IDLE;
            end
        end
    end

    assign drop_sum = {1'b0, drop_count_q} + {15'd0, drop_add};

    // Two-stage read: registered memory output feeding a show-ahead output register
    assign out_ld = m_valid_q && (!out_valid_q || bus.out_ready);
    assign rd_en  = (rd_ptr_q != cm_ptr_q) && (!m_valid_q || out_ld);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            cm_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            pkt_count_q  <= '0;
            drop_count_q <= '0;
            m_valid_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_word_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            cm_ptr_q     <= cm_ptr_d;
            pkt_count_q  <= pkt_count_q + {15'd0, pkt_inc};
            drop_count_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            if (rd_en) rd_ptr_q <= rd_ptr_q + ONE_P;
            if (rd_en) m_valid_q <= 1'b1;
            else if (out_ld) m_valid_q <= 1'b0;
            if (out_ld) begin
                out_word_q  <= m_word_q;
                out_valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr[DEPTH_LOG2-1:0]] <= wr_word;
        if (rd_en) m_word_q <= mem[rd_ptr_q[DEPTH_LOG2-1:0]];
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sop   = out_word_q[68];
    assign bus.out_eop   = out_word_q[67];
    assign bus.out_empty = out_word_q[66:64];
    assign bus.out_data  = out_word_q[63:0];
    assign pkt_count     = pkt_count_q;
    assign drop_count    = drop_count_q;
endmodule

// File: doc/rx_pkt_fifo.md
# rx_pkt_fifo

Per-port ingress packet buffer between a MAC receive stream and one `packetin_N` input of the packet-memory group. It stores each 64-bit Avalon-ST packet and releases only complete, error-free packets downstream (store-and-forward). Packets are discarded whole when space runs out or the MAC flags an error. The MAC side has no backpressure; the output side honours `out_ready`.

## Interface
- `DEPTH_LOG2`, default 9: buffer depth is 2^DEPTH_LOG2 words of 64-bit data plus sop/eop/empty.
- `clock`  in  1  sole clock; all logic rises on `clock`.
- `reset`  in  1  asynchronous, active-low reset.
- `in_data`  in  64  MAC receive data.
- `in_valid`  in  1  beat present. There is no `in_ready`; every valid beat is consumed or discarded.
- `in_sop`, `in_eop`  in  1 each  packet delimiters.
- `in_empty`  in  3  unused bytes on the eop beat.
- `in_error`  in  1  qualifies the eop beat; 1 marks a bad packet.
- `out_data`  out  64, `out_valid`  out  1, `out_sop`  out  1, `out_eop`  out  1, `out_empty`  out  3: packet stream to `packetin_N`.
- `out_ready`  in  1  downstream accept, ready latency 0.
- `pkt_count`  out  16  committed packets, wraps.
- `drop_count`  out  16  dropped packets, saturates at 0xFFFF.

## Operation
- Pointers: `wr_ptr` (tentative write), `cm_ptr` (commit), `rd_ptr` (read). Each is DEPTH_LOG2+1 bits wide, and arithmetic is modulo 2^(DEPTH_LOG2+1).
- `full` = (`wr_ptr` − `rd_ptr`) == 2^DEPTH_LOG2, computed from registered pointers only. A read in the same cycle does not clear `full` until the next cycle.
- Write FSM states: IDLE, WRITE, DROP.
- **IDLE**
  - Valid beat without sop: ignored, not counted.
  - Valid sop beat with `!full`: write the beat and go to WRITE. If the beat is also eop, apply the eop rule instead and stay in IDLE.
  - Valid sop beat with `full`: `drop_count`++ and go to DROP. If the beat is also eop, stay in IDLE.
- **WRITE**, valid beat:
  - sop (missing eop): rewind `wr_ptr` to `cm_ptr` and `drop_count`++. The new beat is then handled as an IDLE sop using the rewound pointer.
  - `full`: rewind to `cm_ptr`, `drop_count`++. Go to DROP, or to IDLE if the beat is eop.
  - Otherwise write the beat; on eop apply the eop rule and go to IDLE.
- **Eop rule**:
  - `in_error`=0: `cm_ptr` ← `wr_ptr`+1 and `pkt_count`++.
  - `in_error`=1: `wr_ptr` ← `cm_ptr` and `drop_count`++.
- **DROP**: discard beats and return to IDLE on eop. A sop beat is handled as in IDLE.
- Packets longer than 2^DEPTH_LOG2 words are always dropped.
- Read side: memory read is registered, followed by a single-entry output register (show-ahead).
  - `out_valid` is 1 whenever the output register holds a committed word.
  - The register loads when empty or when the current word transfers (`out_valid`&&`out_ready`).
  - `rd_ptr` advances on each load. Loading never passes `cm_ptr`.
- Output beats carry the stored sop/eop/empty. `out_empty` is meaningful only on eop.

## Timing
- Reset (async assert, sync deassert to `clock`):
  - Pointers 0, FSM IDLE.
  - `out_valid`=0; `out_data`/`out_sop`/`out_eop`/`out_empty`=0.
  - Counters 0; contents discarded.
  - A packet in flight at reset is lost and is not counted.
- Latency: with the buffer empty and `out_ready`=1, a committing eop accepted at edge N gives `out_valid`=1 with `out_sop`=1 after edge N+2.
- After the first word, a packet streams at one word per clock while `out_ready`=1, with no bubbles.
- While `out_valid`&&!`out_ready`, all `out_*` hold stable.
- Write and read in the same cycle are both performed.
- `cm_ptr` changes only on a good eop. `rd_ptr` never passes `cm_ptr`, so a partial packet is never visible downstream.

## Test plan
- DEPTH_LOG2=4. Send a 3-beat good packet with data 0x11,0x22,0x33 and empty=5, `out_ready`=1 -> `out_valid` asserts 2 clocks after the eop. Output is 3 beats, sop on 0x11, eop with empty=5 on 0x33. `pkt_count`=1.
- Send a 3-beat packet with `in_error`=1 on eop -> no output, `drop_count`=1. Then a 2-beat good packet -> only that packet emerges, starting at pointer 0.
- With `out_ready`=0, send four 4-beat good packets (16 words), then a 5th -> the 5th is dropped, `drop_count`=1, `pkt_count`=4. Raise `out_ready` -> 16 words emerge in order.
- Send an 18-beat packet into the empty buffer -> dropped, `drop_count`=1, no output, `wr_ptr`==`cm_ptr`.
- Send sop, 0xAA, then sop 0xBB, 0xCC eop without an intervening eop -> the first packet is dropped (`drop_count`=1). Output is 0xBB(sop),0xCC(eop).
- Toggle `out_ready` 1-0-1-0 during a 4-beat packet -> every beat appears exactly once and data is stable while stalled. Assert `reset` mid-stream -> `out_valid`=0 immediately and counters 0.
